value_unswapper: RTL

VALUE_UNSWAPPER -- requirements
Module: value_unswapper

---
 rtl/value_unswapper.sv | 83 ++++++++
 1 files changed

// File: rtl/value_unswapper.sv
// Restores pairs of values that were conditionally swapped by the sender.
// A 4-bit key selects, per position in a 4-pair frame, whether A/B were
// exchanged; the block undoes that and presents the pair on a registered
// valid/ready output stage with single-cycle latency.
module value_unswapper #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             LoadKey,
    input  logic [3:0]       Key,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       PairIndex,
    output logic             FrameDone
);

    typedef enum logic {
        NOKEY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] key;
    logic [1:0] cnt;
    logic       accept;

    // Input handshake: needs a key, no key load this cycle, and room in the output stage.
    always_comb begin
        InReady = 1'b0;
        if (nReset && (state == ACTIVE) && !LoadKey && (!OutValid || OutReady)) begin
            InReady = 1'b1;
        end
        accept = InValid && InReady;
    end

    // Key/state control plus the registered output stage.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state     <= NOKEY;
            key       <= '0;
            cnt       <= '0;
            OutValid  <= 1'b0;
            X         <= '0;
            Y         <= '0;
            PairIndex <= '0;
            FrameDone <= 1'b0;
        end else begin
            // A key load is only taken once the output stage is empty, so
            // the pending pair is never reinterpreted against a new key.
            if (LoadKey && !OutValid) begin
                key   <= Key;
                cnt   <= '0;
                state <= ACTIVE;
            end

            // accept implies LoadKey==0, so it never races the counter clear above.
            if (accept) begin
                if (key[cnt]) begin
                    X <= B;
                    Y <= A;
                end else begin
                    X <= A;
                    Y <= B;
                end
                PairIndex <= cnt;
                FrameDone <= (cnt == 2'd3);
                OutValid  <= 1'b1;
                cnt       <= cnt + 2'd1;
            end else if (OutValid && OutReady) begin
                OutValid  <= 1'b0;
                FrameDone <= 1'b0;
            end
        end
    end

endmodule
